// File: rtl/sdmac_arb_pkg.sv
// Shared types and default sizing for the DMA bus-mastership arbiter.
package sdmac_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_FREE = 3'd2,
        ST_OWN       = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_HOLDOFF   = 3'd5
    } arbState_t;

    localparam int DEF_MAX_BEATS = 16;
    localparam int DEF_HOLDOFF   = 4;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchroniser for an active-low asynchronous bus signal.
// Both flops reset to 1 so the synchronised view starts out deasserted.
module bus_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Shift the async level through two flops to settle metastability
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/dma_bus_arbiter.sv
// 68030 bus-mastership sequencer for the DMA engine: runs the BR_/BG_/BGACK_
// handshake, waits for a free bus, grants a bounded tenure of transfers and
// then forces a holdoff so the host CPU gets the bus back.
// All outputs are registered and decoded from the next state.
module dma_bus_arbiter
    import sdmac_arb_pkg::*;
#(
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_dmaena,
    input  logic             i_xfer_req,
    input  logic             i_xfer_done,
    input  logic             i_cycle_active,
    input  logic             i_bg_n,
    input  logic             i_as_n,
    input  logic             i_bgack_n,
    output logic             o_br_n,
    output logic             o_bgack_out,
    output logic             o_own,
    output logic             o_last,
    output logic [CNT_W-1:0] o_tenure_cnt
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BEATS - 1);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic [CNT_W-1:0]  r_tenureCnt;
    logic [CNT_W-1:0]  w_tenureNext;
    logic [HOLD_W-1:0] r_holdCnt;
    logic              r_brN;
    logic              r_bgackOut;
    logic              r_own;
    logic              r_last;
    logic              w_sBgN;
    logic              w_sAsN;
    logic              w_sBgackN;
    logic              w_atLast;
    logic              w_enterOwn;
    logic              w_counting;

    bus_sync2 u_syncBg    (.i_clk(i_clk), .i_reset(i_reset), .i_async(i_bg_n),    .o_sync(w_sBgN));
    bus_sync2 u_syncAs    (.i_clk(i_clk), .i_reset(i_reset), .i_async(i_as_n),    .o_sync(w_sAsN));
    bus_sync2 u_syncBgack (.i_clk(i_clk), .i_reset(i_reset), .i_async(i_bgack_n), .o_sync(w_sBgackN));

    assign w_atLast   = (r_tenureCnt == CNT_LAST);
    assign w_enterOwn = (r_state != ST_OWN) && (w_nextState == ST_OWN);
    assign w_counting = (r_state == ST_OWN) || (r_state == ST_RELEASE);

    // Next-state decision for the mastership handshake and tenure lifecycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_dmaena && i_xfer_req) w_nextState = ST_REQ;
            end
            ST_REQ: begin
                if (!w_sBgN)                         w_nextState = ST_WAIT_FREE;
                else if (!i_dmaena || !i_xfer_req)   w_nextState = ST_IDLE;
            end
            ST_WAIT_FREE: begin
                if (w_sAsN && w_sBgackN)             w_nextState = ST_OWN;
                else if (w_sBgN)                     w_nextState = ST_REQ;
                else if (!i_dmaena)                  w_nextState = ST_IDLE;
            end
            ST_OWN: begin
                if ((i_xfer_done && w_atLast) || !i_dmaena || (!i_xfer_req && !i_cycle_active))
                    w_nextState = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!i_cycle_active) w_nextState = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (r_holdCnt == HOLD_LAST) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Tenure count: cleared on entering OWN, counts completed beats while owning or draining, saturates
    always_comb begin
        w_tenureNext = r_tenureCnt;
        if (w_enterOwn)
            w_tenureNext = '0;
        else if (w_counting && i_xfer_done && (r_tenureCnt != CNT_MAX))
            w_tenureNext = r_tenureCnt + CNT_W'(1);
    end

    // State register with outputs decoded from the next state so nothing is combinational to the pins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_tenureCnt <= '0;
            r_brN       <= 1'b1;
            r_bgackOut  <= 1'b0;
            r_own       <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_tenureCnt <= w_tenureNext;
            r_brN       <= !((w_nextState == ST_REQ) || (w_nextState == ST_WAIT_FREE));
            r_bgackOut  <= (w_nextState == ST_OWN) || (w_nextState == ST_RELEASE);
            r_own       <= (w_nextState == ST_OWN);
            r_last      <= (w_nextState == ST_OWN) && (w_tenureNext == CNT_LAST);
        end
    end

    // Holdoff timer runs only while parked in HOLDOFF and is zero on every entry
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_holdCnt <= '0;
        else if ((r_state == ST_HOLDOFF) && (w_nextState == ST_HOLDOFF))
            r_holdCnt <= r_holdCnt + HOLD_W'(1);
        else
            r_holdCnt <= '0;
    end

    assign o_br_n       = r_brN;
    assign o_bgack_out  = r_bgackOut;
    assign o_own        = r_own;
    assign o_last       = r_last;
    assign o_tenure_cnt = r_tenureCnt;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with default sizing (16 beats, 4-cycle holdoff).
// Inputs change 1 time unit after each rising edge and outputs are checked there.
module tb_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       dmaena, xferReq, xferDone, cycleActive;
    logic       bgN, asN, bgackN;
    logic       brN, bgackOut, own, last;
    logic [4:0] tenureCnt;

    int nCompared   = 0;
    int nMismatched = 0;

    dma_bus_arbiter #(.MAX_BEATS(16), .HOLDOFF(4), .CNT_W(5)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_dmaena(dmaena),
        .i_xfer_req(xferReq),
        .i_xfer_done(xferDone),
        .i_cycle_active(cycleActive),
        .i_bg_n(bgN),
        .i_as_n(asN),
        .i_bgack_n(bgackN),
        .o_br_n(brN),
        .o_bgack_out(bgackOut),
        .o_own(own),
        .o_last(last),
        .o_tenure_cnt(tenureCnt)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ena, input logic req, input logic done,
                                 input logic act, input logic bg, input logic as_n,
                                 input logic bgack);
        dmaena      = ena;
        xferReq     = req;
        xferDone    = done;
        cycleActive = act;
        bgN         = bg;
        asN         = as_n;
        bgackN      = bgack;
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expBr, input logic expBgack,
                               input logic expOwn, input logic expLast);
        checkVal($sformatf("%s.br_n", tag),  {7'd0, brN},      {7'd0, expBr});
        checkVal($sformatf("%s.bgack", tag), {7'd0, bgackOut}, {7'd0, expBgack});
        checkVal($sformatf("%s.own", tag),   {7'd0, own},      {7'd0, expOwn});
        checkVal($sformatf("%s.last", tag),  {7'd0, last},     {7'd0, expLast});
    endtask

    task automatic checkCnt(input string tag, input logic [4:0] expCnt);
        checkVal($sformatf("%s.cnt", tag), {3'd0, tenureCnt}, {3'd0, expCnt});
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        tick();
        tick();
        checkOutput("reset", 1, 0, 0, 0);
        checkCnt("reset", 0);
        reset = 1'b0;

        // Basic tenure: request, grant three cycles after BR_ falls, free bus
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        tick();
        checkOutput("req", 0, 0, 0, 0);
        tick();
        checkOutput("reqHold1", 0, 0, 0, 0);
        tick();
        checkOutput("reqHold2", 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput($sformatf("grantWait%0d", k), 0, 0, 0, 0);
        end
        tick();
        checkOutput("ownEntry", 1, 1, 1, 0);
        checkCnt("ownEntry", 0);

        // Tenure limit: sixteen completed transfers end the tenure
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, 1, 1, 1, 1, 1, 1);
            tick();
            checkOutput($sformatf("beat%0d", i), 1, 1, (i < 16), (i == 15));
            checkCnt($sformatf("beat%0d", i), 5'(i));
            applyStimulus(1, 1, 0, 1, 1, 1, 1);
            tick();
        end
        checkOutput("releaseHold", 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        tick();
        checkOutput("holdoffEntry", 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("holdoff%0d", k), 1, 0, 0, 0);
        end
        tick();
        checkOutput("reRequest", 0, 0, 0, 0);

        // Bus busy: grant arrives while another master holds AS_ for five cycles
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("busy%0d", k), 0, 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 0, 1, 1);
        for (int k = 6; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("busy%0d", k), 0, 0, 0, 0);
        end
        tick();
        checkOutput("busyOwn", 1, 1, 1, 0);
        checkCnt("busyOwn", 0);

        // Early end: requester runs dry after five transfers with no cycle in flight
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 1, 1, 1, 1, 1, 1);
            tick();
            applyStimulus(1, 1, 0, 1, 1, 1, 1);
            tick();
        end
        checkOutput("early5", 1, 1, 1, 0);
        checkCnt("early5", 5);
        applyStimulus(1, 0, 0, 0, 1, 1, 1);
        tick();
        checkOutput("earlyRelease", 1, 1, 0, 0);
        checkCnt("earlyRelease", 5);
        tick();
        checkOutput("earlyHoldoff", 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("earlyIdle%0d", k), 1, 0, 0, 0);
        end

        // Withdrawal: request dropped before any grant
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        tick();
        checkOutput("wdReq", 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 1);
        tick();
        checkOutput("wdIdle", 1, 0, 0, 0);
        tick();
        checkOutput("wdIdleHold", 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        tick();
        checkOutput("wdReReq", 0, 0, 0, 0);

        // Reset mid-tenure with a bus cycle in flight
        applyStimulus(1, 1, 0, 1, 0, 1, 1);
        for (int k = 1; k <= 4; k++) tick();
        checkOutput("rstOwn", 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 1, 1);
        tick();
        applyStimulus(1, 1, 0, 1, 0, 1, 1);
        tick();
        applyStimulus(1, 1, 1, 1, 0, 1, 1);
        tick();
        checkCnt("rstBeats", 2);
        applyStimulus(1, 1, 0, 1, 0, 1, 1);
        reset = 1'b1;
        tick();
        checkOutput("rstMid", 1, 0, 0, 0);
        checkCnt("rstMid", 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        tick();
        checkOutput("rstAfter", 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
